// File: rtl/alu_mc_if.sv
// Issue/writeback handshake bundle for alu_mc: operand request side and
// registered result/flag side, each with its own valid/ready pair.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       opcode;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             sign;
    logic             carry;
    logic             overflow;
    logic             parity;
    logic             div_by_zero;

    modport master (
        output in_valid, a, b, opcode, cin, out_ready,
        input  in_ready, out_valid, result, zero, sign, carry, overflow, parity, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, opcode, cin, out_ready,
        output in_ready, out_valid, result, zero, sign, carry, overflow, parity, div_by_zero
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative MUL (and DIV when
// ALU_MC_DIV_EN is defined); result and flags held until the consumer accepts.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               zero_q, zero_d, sign_q, sign_d, carry_q, carry_d;
    logic               ovf_q, ovf_d, par_q, par_d, dz_q, dz_d;

    logic [WIDTH:0]     sum, diff, msum;
    logic [2*WIDTH-1:0] mnext;
    logic [WIDTH-1:0]   fin;
    logic               fin_c, fin_v, fin_dz, done;

    // acc holds {partial product, remaining multiplier bits}; one add-and-shift per cycle
    always_comb begin
        msum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mnext = {msum, acc_q[WIDTH-1:1]};
    end

`ifdef ALU_MC_DIV_EN
    logic               div_q, div_d;
    logic [WIDTH:0]     dsh, dsub;
    logic [2*WIDTH-1:0] dnext;

    // acc holds {remainder, dividend/quotient}; the bit shifted out of the
    // remainder is kept in dsh so the trial subtract never loses it
    always_comb begin
        dsh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        dsub  = dsh - {1'b0, opnd_q};
        dnext = dsub[WIDTH] ? {dsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                            : {dsub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
`endif

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        res_d   = res_q;
        zero_d  = zero_q;
        sign_d  = sign_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        par_d   = par_q;
        dz_d    = dz_q;
`ifdef ALU_MC_DIV_EN
        div_d   = div_q;
`endif
        fin     = '0;
        fin_c   = 1'b0;
        fin_v   = 1'b0;
        fin_dz  = 1'b0;
        done    = 1'b0;
        sum     = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
        diff    = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.cin};

        case (state_q)
            IDLE: if (bus.in_valid) begin
                done = 1'b1;
                case (bus.opcode)
                    4'd0: begin
                        fin   = sum[WIDTH-1:0];
                        fin_c = sum[WIDTH];
                        fin_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
                    end
                    4'd1: begin
                        fin   = diff[WIDTH-1:0];
                        fin_c = diff[WIDTH];
                        fin_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
                    end
                    4'd2:  fin = ~bus.a;
                    4'd3:  fin = bus.a & bus.b;
                    4'd4:  fin = bus.a | bus.b;
                    4'd5:  fin = ~(bus.a | bus.b);
                    4'd6:  fin = ~(bus.a & bus.b);
                    4'd7:  fin = bus.a ^ bus.b;
                    4'd8:  fin = ~(bus.a ^ bus.b);
                    4'd9: begin
                        done    = 1'b0;
                        opnd_d  = bus.a;
                        acc_d   = {{WIDTH{1'b0}}, bus.b};
                        cnt_d   = '0;
                        state_d = CALC;
`ifdef ALU_MC_DIV_EN
                        div_d   = 1'b0;
`endif
                    end
                    4'd10: begin
`ifdef ALU_MC_DIV_EN
                        if (bus.b == '0) begin
                            fin    = '1;
                            fin_dz = 1'b1;
                        end else begin
                            done    = 1'b0;
                            opnd_d  = bus.b;
                            acc_d   = {{WIDTH{1'b0}}, bus.a};
                            cnt_d   = '0;
                            div_d   = 1'b1;
                            state_d = CALC;
                        end
`else
                        fin = '0;
`endif
                    end
                    4'd11: fin = WIDTH'(bus.a == bus.b);
                    4'd12: fin = WIDTH'(bus.a > bus.b);
                    4'd13: begin
                        fin   = {bus.a[WIDTH-2:0], 1'b0};
                        fin_c = bus.a[WIDTH-1];
                    end
                    4'd14: begin
                        fin   = {1'b0, bus.a[WIDTH-1:1]};
                        fin_c = bus.a[0];
                    end
                    default: fin = '0;
                endcase
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
`ifdef ALU_MC_DIV_EN
                acc_d = div_q ? dnext : mnext;
`else
                acc_d = mnext;
`endif
                if (cnt_q == LAST) begin
                    done  = 1'b1;
                    fin   = mnext[WIDTH-1:0];
                    fin_v = |mnext[2*WIDTH-1:WIDTH];
`ifdef ALU_MC_DIV_EN
                    if (div_q) begin
                        fin   = dnext[WIDTH-1:0];
                        fin_v = 1'b0;
                    end
`endif
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (done) begin
            state_d = DONE;
            res_d   = fin;
            zero_d  = (fin == '0);
            sign_d  = fin[WIDTH-1];
            par_d   = ^fin;
            carry_d = fin_c;
            ovf_d   = fin_v;
            dz_d    = fin_dz;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opnd_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            sign_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            par_q   <= 1'b0;
            dz_q    <= 1'b0;
`ifdef ALU_MC_DIV_EN
            div_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            sign_q  <= sign_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            par_q   <= par_d;
            dz_q    <= dz_d;
`ifdef ALU_MC_DIV_EN
            div_q   <= div_d;
`endif
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.result      = res_q;
    assign bus.zero        = zero_q;
    assign bus.sign        = sign_q;
    assign bus.carry       = carry_q;
    assign bus.overflow    = ovf_q;
    assign bus.parity      = par_q;
    assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed-vector bench for alu_mc at WIDTH=32; flag vector is {zero,sign,carry,overflow,parity,div_by_zero}.
module tb_alu_mc;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_mc_if #(.WIDTH(W)) bus ();
    alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic [5:0] flg;
    assign flg = {bus.zero, bus.sign, bus.carry, bus.overflow, bus.parity, bus.div_by_zero};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // drive one operation, wait for acceptance, then scramble inputs to prove they are ignored
    task automatic send(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
        int g = 0;
        @(negedge clk);
        while (!bus.in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("ready_before_issue", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.a        = av;
        bus.b        = bv;
        bus.cin      = c;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.opcode   = ~op;
        bus.a        = ~av;
        bus.b        = ~bv;
        bus.cin      = ~c;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input logic c, input int exp_lat,
                         input logic [W-1:0] er, input logic [5:0] ef);
        int lat;
        send(op, av, bv, c);
        wait_out(lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, bus.result, er);
        chk({tag, "_flags"}, flg, ef);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_ready_after"}, bus.in_ready, 1);
        chk({tag, "_valid_after"}, bus.out_valid, 0);
        chk({tag, "_res_held"}, bus.result, er);
    endtask

    initial begin
        int lat;
        logic seen;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.opcode    = '0;
        bus.cin       = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_held_ready", bus.in_ready, 1);
        chk("rst_held_valid", bus.out_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_flags", flg, 6'b000000);

        //     tag       op     a             b             cin lat  result        z s c v p dz
        do_op("add_wrap", 4'd0, 32'hFFFFFFFF, 32'h00000001, 0, 1, 32'h00000000, 6'b101000);
        do_op("add_cin",  4'd0, 32'h7FFFFFFF, 32'h00000000, 1, 1, 32'h80000000, 6'b010110);
        do_op("sub_ovf",  4'd1, 32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 6'b000110);
        do_op("sub_brw",  4'd1, 32'h00000000, 32'h00000001, 0, 1, 32'hFFFFFFFF, 6'b011000);
        do_op("not",      4'd2, 32'h00000000, 32'h12345678, 0, 1, 32'hFFFFFFFF, 6'b010000);
        do_op("xor",      4'd7, 32'hF0F0F0F0, 32'hFF00FF00, 0, 1, 32'h0FF00FF0, 6'b000000);
        do_op("nand",     4'd6, 32'hFFFFFFFF, 32'h00000000, 0, 1, 32'hFFFFFFFF, 6'b010000);
        do_op("nor",      4'd5, 32'h0000000F, 32'h000000F0, 0, 1, 32'hFFFFFF00, 6'b010000);
        do_op("eq",       4'd11, 32'h5,       32'h3,        0, 1, 32'h0,        6'b100000);
        do_op("gt",       4'd12, 32'h5,       32'h3,        0, 1, 32'h1,        6'b000010);
        do_op("gt_uns",   4'd12, 32'h1,       32'h80000000, 0, 1, 32'h0,        6'b100000);
        do_op("shr",      4'd14, 32'h00000003, 32'h0,       0, 1, 32'h1,        6'b001010);
        do_op("op15",     4'd15, 32'hDEADBEEF, 32'h1,       0, 1, 32'h0,        6'b100000);
        do_op("mul_ovf",  4'd9, 32'h00010000, 32'h00010000, 0, 33, 32'h0,       6'b100100);
        do_op("mul_7x6",  4'd9, 32'h7,        32'h6,        0, 33, 32'h2A,      6'b000010);
`ifdef ALU_MC_DIV_EN
        do_op("div_100_7", 4'd10, 32'd100,    32'd7,        0, 33, 32'd14,      6'b000010);
        do_op("div_by_0",  4'd10, 32'd5,      32'd0,        0, 1, 32'hFFFFFFFF, 6'b010001);
`else
        do_op("div_off",   4'd10, 32'd100,    32'd7,        0, 1, 32'h0,        6'b100000);
`endif

        // result held under backpressure
        send(4'd13, 32'h80000001, 32'h0, 1'b0);
        wait_out(lat);
        chk("shl_lat", lat, 1);
        for (int i = 0; i < 10; i++) begin
            chk("shl_hold_res", bus.result, 32'h00000002);
            chk("shl_hold_carry", bus.carry, 1);
            chk("shl_hold_busy", {bus.in_ready, bus.out_valid}, 2'b01);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("shl_release_ready", bus.in_ready, 1);
        chk("shl_release_valid", bus.out_valid, 0);

        // reset in the middle of a multiply aborts it
        send(4'd9, 32'h7, 32'h6, 1'b0);
        repeat (5) @(negedge clk);
        chk("mid_mul_busy", bus.in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_mul_rst_ready", bus.in_ready, 1);
        chk("mid_mul_rst_valid", bus.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_mul_rst_result", bus.result, 0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("mid_mul_no_valid", seen, 0);
        chk("mid_mul_idle", bus.in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
